line_fetch_ctrl: RTL



---
 rtl/line_fetch_ctrl_pkg.sv | 25 ++
 rtl/line_fetch_ctrl_bin2bcd3.sv | 27 ++
 rtl/line_fetch_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/line_fetch_ctrl_pkg.sv
// Shared constants and types for the text-row fetch path: screen geometry,
// BCD glyph encoding and the fetch controller state encoding.
package line_fetch_ctrl_pkg;

  localparam int HCHAR      = 48;
  localparam int VCHAR      = 18;
  localparam int DIG        = 3;
  localparam int BITPERCH   = 4;
  localparam int ROW_VALS   = HCHAR / DIG;
  localparam int PAGE_VALS  = VCHAR * ROW_VALS;
  localparam int PAGE_BITS  = 4;
  localparam logic [BITPERCH-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Line-buffer word that renders as an empty value field.
  function automatic logic [BITPERCH*DIG-1:0] blank_word();
    return {DIG{BLANK_CODE}};
  endfunction

endpackage

// File: rtl/line_fetch_ctrl_bin2bcd3.sv
// Combinational binary to three-digit BCD converter (double dabble),
// saturating at 999 so oversized values still render as a full field.
module bin2bcd3 #(
  parameter int N = 10
) (
  input  logic [N-1:0] i_bin,
  output logic [11:0]  o_bcd
);

  logic [N-1:0] w_clip;
  logic [11:0]  w_bcd;

  assign w_clip = (i_bin > N'(999)) ? N'(999) : i_bin;

  // Shift-and-add-3: correct each digit before every shift so it stays decimal.
  always_comb begin
    w_bcd = 12'd0;
    for (int i = N - 1; i >= 0; i--) begin
      w_bcd[3:0]  = (w_bcd[3:0]  > 4'd4) ? w_bcd[3:0]  + 4'd3 : w_bcd[3:0];
      w_bcd[7:4]  = (w_bcd[7:4]  > 4'd4) ? w_bcd[7:4]  + 4'd3 : w_bcd[7:4];
      w_bcd[11:8] = (w_bcd[11:8] > 4'd4) ? w_bcd[11:8] + 4'd3 : w_bcd[11:8];
      w_bcd       = {w_bcd[10:0], w_clip[i]};
    end
    o_bcd = w_bcd;
  end

endmodule

// File: rtl/line_fetch_ctrl.sv
// Fills the character line buffer for one text row: reads the row's values
// from the result RAM, converts them to BCD and writes one slot per cycle.
module line_fetch_ctrl
  import line_fetch_ctrl_pkg::*;
#(
  parameter int N        = 10,
  parameter int L        = 230,
  parameter int ADR_BITS = 10
) (
  input  logic                      clk,
  input  logic                      RSTn,
  input  logic                      row_start,
  input  logic [4:0]                row_idx,
  input  logic                      page_next,
  output logic                      rd_en,
  output logic [ADR_BITS-1:0]       rd_addr,
  input  logic [N-1:0]              rd_data,
  output logic                      lb_we,
  output logic [3:0]                lb_slot,
  output logic [BITPERCH*DIG-1:0]   lb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int NPAGES = (L + PAGE_VALS - 1) / PAGE_VALS;

  state_t                    r_state;
  logic [3:0]                r_slot;
  logic [4:0]                r_row;
  logic [PAGE_BITS-1:0]      r_page;
  logic [PAGE_BITS-1:0]      r_page_lat;
  logic                      r_pend_vld;
  logic [4:0]                r_pend_row;
  logic                      r_rd_en;
  logic [ADR_BITS-1:0]       r_rd_addr;
  logic                      r_p1_vld;
  logic [3:0]                r_p1_slot;
  logic                      r_p1_blank;
  logic                      r_p2_vld;
  logic [3:0]                r_p2_slot;
  logic                      r_p2_blank;
  logic                      r_lb_we;
  logic [3:0]                r_lb_slot;
  logic [BITPERCH*DIG-1:0]   r_lb_data;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_overrun;

  logic [15:0]               w_idx;
  logic                      w_hit;
  logic [11:0]               w_bcd;

  assign w_idx = 16'(r_page_lat) * 16'(PAGE_VALS) + 16'(r_row) * 16'(ROW_VALS) + 16'(r_slot);
  assign w_hit = (w_idx < 16'(L));

  bin2bcd3 #(.N(N)) u_bcd (
    .i_bin (rd_data),
    .o_bcd (w_bcd)
  );

  // Display page counter; only sampled into r_page_lat when a fill starts.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_page <= '0;
    end else if (page_next) begin
      r_page <= (r_page == PAGE_BITS'(NPAGES - 1)) ? '0 : r_page + 4'd1;
    end
  end

  // Row sequencer: issues reads, tags each slot, tracks one pending request.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_slot     <= 4'd0;
      r_row      <= 5'd0;
      r_page_lat <= '0;
      r_pend_vld <= 1'b0;
      r_pend_row <= 5'd0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_slot  <= 4'd0;
      r_p1_blank <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rd_en  <= 1'b0;
      r_p1_vld <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (row_start) begin
            r_row      <= row_idx;
            r_page_lat <= r_page;
            r_slot     <= 4'd0;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_busy     <= 1'b1;
          r_rd_en    <= w_hit;
          r_rd_addr  <= w_hit ? w_idx[ADR_BITS-1:0] : r_rd_addr;
          r_p1_vld   <= 1'b1;
          r_p1_slot  <= r_slot;
          r_p1_blank <= ~w_hit;
          r_slot     <= r_slot + 4'd1;
          if (r_slot == 4'(ROW_VALS - 1)) begin
            r_state <= ST_DRAIN;
          end
          if (row_start) begin
            r_pend_row <= row_idx;
            r_pend_vld <= 1'b1;
            r_overrun  <= r_overrun | r_pend_vld;
          end
        end
        ST_DRAIN: begin
          r_busy <= 1'b1;
          // Both tag stages empty means the last slot's write is on lb_*.
          if (!r_p1_vld && !r_p2_vld) begin
            r_done <= 1'b1;
            if (r_pend_vld) begin
              r_row      <= r_pend_row;
              r_page_lat <= r_page;
              r_slot     <= 4'd0;
              r_state    <= ST_FETCH;
              r_pend_vld <= row_start;
              r_pend_row <= row_idx;
            end else if (row_start) begin
              r_row      <= row_idx;
              r_page_lat <= r_page;
              r_slot     <= 4'd0;
              r_state    <= ST_FETCH;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (row_start) begin
            r_pend_row <= row_idx;
            r_pend_vld <= 1'b1;
            r_overrun  <= r_overrun | r_pend_vld;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data stage: slot tag waits one cycle for rd_data, then lands on lb_*.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_p2_vld   <= 1'b0;
      r_p2_slot  <= 4'd0;
      r_p2_blank <= 1'b0;
      r_lb_we    <= 1'b0;
      r_lb_slot  <= 4'd0;
      r_lb_data  <= '0;
    end else begin
      r_p2_vld   <= r_p1_vld;
      r_p2_slot  <= r_p1_slot;
      r_p2_blank <= r_p1_blank;
      r_lb_we    <= r_p2_vld;
      if (r_p2_vld) begin
        r_lb_slot <= r_p2_slot;
        r_lb_data <= r_p2_blank ? blank_word() : w_bcd;
      end
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign lb_we   = r_lb_we;
  assign lb_slot = r_lb_slot;
  assign lb_data = r_lb_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule
